cam_array: RTL

- Parametrised content-addressable memory of DEPTH entries, each DATA_W wide, with a per-entry valid bit.
- Supports addressed write, addressed read, single-entry invalidate, global flush and a pipelined search with priority-encoded match index.
- Generalises the single CAM word into a self-contained array, with occupancy tracking and multi-hit detection.
- Sits between the lookup requester and any table-management logic that allocates entries.

---
 rtl/cam_pkg.sv | 24 ++
 rtl/cam_prio_enc.sv | 30 +++
 rtl/cam_array.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// Shared types and helpers for the cam_array content-addressable memory.
// Optional masked search is enabled by defining CAM_MASK_EN.
package cam_pkg;

  // Default array depth; cam_match_t is sized from this value.
  localparam int CAM_DEPTH_DEF = 16;

  // Width of the index field carried in search responses (DEPTH <= 256).
  localparam int CAM_IDX_MAX_W = 8;

  // Index width for a given depth; a depth of 1 still needs one bit.
  function automatic int cam_idx_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  typedef logic [CAM_DEPTH_DEF-1:0] cam_match_t;

  typedef struct packed {
    logic                     hit;
    logic [CAM_IDX_MAX_W-1:0] index;
    logic                     multi;
  } cam_search_rsp_t;

endpackage

// File: rtl/cam_prio_enc.sv
// Combinational priority encoder for the CAM match vector: reports any hit,
// the lowest matching index and whether more than one entry matched.
module cam_prio_enc
  import cam_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH-1:0] i_match,
  output cam_search_rsp_t  o_rsp
);

  // Ascending scan: the first set bit gives the index, any later one flags multi.
  always_comb begin
    logic w_found;
    w_found = 1'b0;
    o_rsp   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_match[i]) begin
        if (w_found) begin
          o_rsp.multi = 1'b1;
        end else begin
          w_found     = 1'b1;
          o_rsp.index = CAM_IDX_MAX_W'(i);
        end
      end
    end
    o_rsp.hit = w_found;
  end

endmodule

// File: rtl/cam_array.sv
// cam_array: DEPTH x DATA_W content-addressable memory with per-entry valid
// bits, addressed read/write/invalidate, global flush, occupancy count and a
// one-cycle pipelined search with priority-encoded result.
// Define CAM_MASK_EN to enable per-bit care masking on search.
module cam_array
  import cam_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,
  localparam int IDX_W  = cam_idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              inv_en,
  input  logic [IDX_W-1:0]  inv_index,
  input  logic              flush,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_index,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              search_en,
  input  logic [DATA_W-1:0] search_key,
  input  logic [DATA_W-1:0] search_mask,
  output logic              search_done,
  output logic              search_hit,
  output logic [IDX_W-1:0]  search_index,
  output logic              search_multi,
  output logic [IDX_W:0]    count,
  output logic              full
);

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_valid;

  logic [DEPTH-1:0]  w_valid_nxt;
  logic [IDX_W:0]    w_cnt_nxt;
  logic [DATA_W-1:0] w_mask;
  logic [DEPTH-1:0]  w_match;
  cam_search_rsp_t   w_rsp;
  logic              w_unused;

`ifdef CAM_MASK_EN
  assign w_mask   = search_mask;
  assign w_unused = ^w_rsp.index;
`else
  // Mask port kept for interface stability; every bit is compared.
  assign w_mask   = {DATA_W{1'b1}};
  assign w_unused = ^{search_mask, w_rsp.index};
`endif

  // Next valid vector: flush clears all, invalidate clears one, write sets
  // one last so a write wins over both on its own entry.
  always_comb begin
    w_valid_nxt = flush ? '0 : r_valid;
    if (inv_en) w_valid_nxt[inv_index] = 1'b0;
    if (wr_en)  w_valid_nxt[wr_index]  = 1'b1;
  end

  // Occupancy is the exact population count of the next valid vector.
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt_nxt = w_cnt_nxt + (IDX_W+1)'(w_valid_nxt[i]);
    end
  end

  // Per-entry match against pre-edge contents.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = r_valid[i] && (((r_data[i] ^ search_key) & w_mask) == '0);
    end
  end

  cam_prio_enc #(
    .DEPTH (DEPTH)
  ) u_prio_enc (
    .i_match (w_match),
    .o_rsp   (w_rsp)
  );

  // Stored words: cleared on reset, otherwise only an addressed write changes them.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
    end else if (wr_en) begin
      r_data[wr_index] <= wr_data;
    end
  end

  // Valid bits and occupancy move together on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      count   <= '0;
      full    <= 1'b0;
    end else begin
      r_valid <= w_valid_nxt;
      count   <= w_cnt_nxt;
      full    <= (w_cnt_nxt == (IDX_W+1)'(DEPTH));
    end
  end

  // Registered read port; returns zero unless the addressed entry is valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en && r_valid[rd_index];
      rd_data  <= (rd_en && r_valid[rd_index]) ? r_data[rd_index] : '0;
    end
  end

  // Search result stage; all fields are zero on cycles without a search.
  always_ff @(posedge clk) begin
    if (reset) begin
      search_done  <= 1'b0;
      search_hit   <= 1'b0;
      search_index <= '0;
      search_multi <= 1'b0;
    end else begin
      search_done  <= search_en;
      search_hit   <= search_en && w_rsp.hit;
      search_index <= search_en ? w_rsp.index[IDX_W-1:0] : '0;
      search_multi <= search_en && w_rsp.multi;
    end
  end

endmodule
